// File: rtl/cl_serial_pkg.sv
// Shared definitions for the Camera Link serial return path: FSM states,
// byte tags, the register-write field layout and the frame packing helper.
package cl_serial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_GAP   = 3'd4
   } tx_state_e;

   localparam logic [1:0]  TAG_FIRST = 2'b01;
   localparam logic [1:0]  TAG_CONT  = 2'b11;
   localparam int          ENTRY_W   = 18;
   localparam logic [15:0] MIN_BAUD_DFLT     = 16'd8;
   localparam logic [15:0] DEFAULT_BAUD_DFLT = 16'd433;

   // Register-write field layout, identical to the one the receiver decodes
   typedef struct packed {
      logic [1:0] rb;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_entry_t;

   // Three bytes of one acknowledge, byte0 in the low octet (sent first)
   function automatic logic [23:0] pack_frame(input wr_entry_t e);
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
      b0 = {e.addr[3:0], e.rb, TAG_FIRST};
      b1 = {e.data[1:0], e.addr[7:4], TAG_CONT};
      b2 = {e.data[7:2], TAG_CONT};
      return {b2, b1, b0};
   endfunction

endpackage

// File: rtl/cl_sync_fifo.sv
// Single-clock FIFO with occupancy output; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module cl_sync_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty
);

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == DEPTH_L);
   assign empty     = (count_r == LW'(0));
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);
   assign rdata     = mem_r[rd_ptr_r];
   assign level     = count_r;

   // Storage write; the head is read combinationally before being overwritten
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= LW'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + LW'(1);
            2'b01:   count_r <= count_r - LW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/cl_serial_ack.sv
// Camera Link SerTFG write-acknowledge transmitter: queues register writes and
// re-sends each one as three UART bytes at the measured baud period.
module cl_serial_ack
   import cl_serial_pkg::*;
#(
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [15:0] MIN_BAUD     = MIN_BAUD_DFLT,
   parameter logic [15:0] DEFAULT_BAUD = DEFAULT_BAUD_DFLT
) (
   input  logic                         clk_fix,
   input  logic                         rst_fix,
   input  logic                         lvds_swap,
   input  logic [15:0]                  measured_baud,
   input  logic                         rb1_wen,
   input  logic                         rb2_wen,
   input  logic                         rb3_wen,
   input  logic                         rb4_wen,
   input  logic [7:0]                   reg_addr,
   input  logic [7:0]                   reg_data,
   input  logic                         tx_enable,
   output logic                         cl_sertfg,
   output logic                         busy,
   output logic                         overflow,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

   tx_state_e        state_r;
   logic [16:0]      cnt_r;
   logic [16:0]      period_r;
   logic [23:0]      shift_r;
   logic [2:0]       bit_cnt_r;
   logic [1:0]       byte_cnt_r;
   logic             line_q;
   logic             busy_r;
   logic             overflow_r;

   wr_entry_t        entry_s;
   wr_entry_t        head_s;
   logic             wen_any_s;
   logic             push_s;
   logic             pop_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [ENTRY_W-1:0] fifo_rdata_s;
   logic [15:0]      baud_sel_s;
   logic [16:0]      period_next_s;
   logic             bit_end_s;

   // Capture: lowest bank index wins when several strobes coincide
   always_comb begin
      entry_s      = '{rb: 2'd0, addr: reg_addr, data: reg_data};
      wen_any_s    = rb1_wen | rb2_wen | rb3_wen | rb4_wen;
      if (rb1_wen) begin
         entry_s.rb = 2'd0;
      end else if (rb2_wen) begin
         entry_s.rb = 2'd1;
      end else if (rb3_wen) begin
         entry_s.rb = 2'd2;
      end else if (rb4_wen) begin
         entry_s.rb = 2'd3;
      end else begin
         entry_s.rb = 2'd0;
      end
   end

   assign pop_s         = (state_r == ST_IDLE) && !fifo_empty_s && tx_enable;
   assign push_s        = wen_any_s && (!fifo_full_s || pop_s);
   assign head_s        = fifo_rdata_s;
   assign baud_sel_s    = (measured_baud < MIN_BAUD) ? DEFAULT_BAUD : measured_baud;
   assign period_next_s = {1'b0, baud_sel_s} + 17'd1;
   assign bit_end_s     = (cnt_r == (period_r - 17'd1));

   cl_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_fix),
      .rst   (rst_fix),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (entry_s),
      .rdata (fifo_rdata_s),
      .level (fifo_level),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Sticky drop flag
   always_ff @(posedge clk_fix) begin
      if (rst_fix) begin
         overflow_r <= 1'b0;
      end else if (wen_any_s && !push_s) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   // Frame sequencer: bit timing, shift register and registered line level
   always_ff @(posedge clk_fix) begin
      if (rst_fix) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 17'd0;
         period_r   <= 17'd1;
         shift_r    <= 24'd0;
         bit_cnt_r  <= 3'd0;
         byte_cnt_r <= 2'd0;
         line_q     <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= 17'd0;
               if (pop_s) begin
                  period_r   <= period_next_s;
                  shift_r    <= pack_frame(head_s);
                  bit_cnt_r  <= 3'd0;
                  byte_cnt_r <= 2'd0;
                  line_q     <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= ST_START;
               end else begin
                  line_q <= 1'b1;
                  busy_r <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end_s) begin
                  cnt_r     <= 17'd0;
                  bit_cnt_r <= 3'd0;
                  line_q    <= shift_r[0];
                  shift_r   <= {1'b0, shift_r[23:1]};
                  state_r   <= ST_DATA;
               end else begin
                  cnt_r <= cnt_r + 17'd1;
               end
            end
            ST_DATA: begin
               if (bit_end_s) begin
                  cnt_r <= 17'd0;
                  if (bit_cnt_r == 3'd7) begin
                     line_q  <= 1'b1;
                     state_r <= ST_STOP;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                     line_q    <= shift_r[0];
                     shift_r   <= {1'b0, shift_r[23:1]};
                  end
               end else begin
                  cnt_r <= cnt_r + 17'd1;
               end
            end
            ST_STOP: begin
               if (bit_end_s) begin
                  cnt_r <= 17'd0;
                  if (byte_cnt_r < 2'd2) begin
                     byte_cnt_r <= byte_cnt_r + 2'd1;
                     line_q     <= 1'b0;
                     state_r    <= ST_START;
                  end else begin
                     line_q  <= 1'b1;
                     state_r <= ST_GAP;
                  end
               end else begin
                  cnt_r <= cnt_r + 17'd1;
               end
            end
            ST_GAP: begin
               if (bit_end_s) begin
                  cnt_r   <= 17'd0;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + 17'd1;
               end
               line_q <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 17'd0;
               line_q  <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign cl_sertfg = line_q ^ lvds_swap;
   assign busy      = busy_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_cl_serial_ack.sv
// Bench for cl_serial_ack: a UART monitor decodes the line and checks each
// byte against a scoreboard filled with hand-computed acknowledge bytes.
module tb_cl_serial_ack;

   logic        clk_fix = 1'b0;
   logic        rst_fix;
   logic        lvds_swap;
   logic [15:0] measured_baud;
   logic        rb1_wen, rb2_wen, rb3_wen, rb4_wen;
   logic [7:0]  reg_addr;
   logic [7:0]  reg_data;
   logic        tx_enable;
   logic        cl_sertfg;
   logic        busy;
   logic        overflow;
   logic [2:0]  fifo_level;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  sb [$];
   logic        mon_en = 1'b0;
   int          exp_p  = 10;
   int          mon_p;
   logic [7:0]  mon_b;
   logic [7:0]  mon_exp;
   logic        mon_start;
   logic        mon_stop;

   int          cnt;
   int          edges;
   logic        prev;

   cl_serial_ack dut (
      .clk_fix       (clk_fix),
      .rst_fix       (rst_fix),
      .lvds_swap     (lvds_swap),
      .measured_baud (measured_baud),
      .rb1_wen       (rb1_wen),
      .rb2_wen       (rb2_wen),
      .rb3_wen       (rb3_wen),
      .rb4_wen       (rb4_wen),
      .reg_addr      (reg_addr),
      .reg_data      (reg_data),
      .tx_enable     (tx_enable),
      .cl_sertfg     (cl_sertfg),
      .busy          (busy),
      .overflow      (overflow),
      .fifo_level    (fifo_level)
   );

   always #5 clk_fix = ~clk_fix;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_fix);
      #1;
   endtask

   task automatic strobe(input logic [3:0] wens, input logic [7:0] a, input logic [7:0] d);
      {rb4_wen, rb3_wen, rb2_wen, rb1_wen} = wens;
      reg_addr = a;
      reg_data = d;
      tick();
      {rb4_wen, rb3_wen, rb2_wen, rb1_wen} = 4'b0000;
   endtask

   task automatic expect3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      sb.push_back(b0);
      sb.push_back(b1);
      sb.push_back(b2);
   endtask

   task automatic wait_drain(input string name, input int max);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy !== 1'b0 || fifo_level !== 3'd0) && n < max) begin
         tick();
         n++;
      end
      check(name, (n < max) ? 32'd1 : 32'd0, 32'd1);
   endtask

   // UART monitor: samples each bit near its centre on the falling clock edge
   initial begin
      forever begin
         @(negedge clk_fix);
         if (mon_en && ((cl_sertfg ^ lvds_swap) === 1'b0)) begin
            mon_p = exp_p;
            repeat (mon_p / 2) @(negedge clk_fix);
            mon_start = cl_sertfg ^ lvds_swap;
            for (int i = 0; i < 8; i++) begin
               repeat (mon_p) @(negedge clk_fix);
               mon_b[i] = cl_sertfg ^ lvds_swap;
            end
            repeat (mon_p) @(negedge clk_fix);
            mon_stop = cl_sertfg ^ lvds_swap;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got %0h expected none", mon_b);
            end else begin
               mon_exp = sb.pop_front();
               check("byte_value", {16'd0, mon_b}, {24'd0, mon_exp});
               check("byte_framing", {30'd0, mon_start, mon_stop}, 32'd1);
            end
         end
      end
   end

   initial begin
      rst_fix = 1'b1;
      lvds_swap = 1'b0;
      measured_baud = 16'd9;
      {rb4_wen, rb3_wen, rb2_wen, rb1_wen} = 4'b0000;
      reg_addr = 8'h00;
      reg_data = 8'h00;
      tx_enable = 1'b0;
      repeat (3) tick();
      check("rst_line", {31'd0, cl_sertfg}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_level", {29'd0, fifo_level}, 32'd0);
      rst_fix = 1'b0;
      tick();

      // Single write, P = 10: bytes A5 D7 C3
      exp_p = 10;
      mon_en = 1'b1;
      tx_enable = 1'b1;
      expect3(8'hA5, 8'hD7, 8'hC3);
      strobe(4'b0010, 8'h5A, 8'hC3);
      check("push_latency_level", {29'd0, fifo_level}, 32'd1);
      check("pre_start_busy", {31'd0, busy}, 32'd0);
      check("pre_start_line", {31'd0, cl_sertfg}, 32'd1);
      tick();
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_line", {31'd0, cl_sertfg}, 32'd0);
      check("start_level", {29'd0, fifo_level}, 32'd0);
      cnt = 1;
      while (busy === 1'b1 && cnt < 2000) begin
         tick();
         if (busy === 1'b1) cnt++;
      end
      check("busy_len_p10", cnt, 32'd310);
      wait_drain("drain_single", 200);

      // Overflow: 6 strobes with tx disabled, first four kept (P = 9, MIN_BAUD edge)
      tx_enable = 1'b0;
      measured_baud = 16'd8;
      exp_p = 9;
      strobe(4'b0001, 8'h12, 8'h34);
      strobe(4'b1010, 8'hFF, 8'h00);
      strobe(4'b0100, 8'h00, 8'hFF);
      strobe(4'b1000, 8'hA5, 8'h96);
      strobe(4'b0001, 8'h77, 8'h77);
      strobe(4'b0100, 8'h88, 8'h88);
      check("ovf_level", {29'd0, fifo_level}, 32'd4);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      expect3(8'h21, 8'h07, 8'h37);
      expect3(8'hF5, 8'h3F, 8'h03);
      expect3(8'h09, 8'hC3, 8'hFF);
      expect3(8'h5D, 8'hAB, 8'h97);
      tx_enable = 1'b1;
      cnt = 0;
      while (busy !== 1'b1 && cnt < 10) begin tick(); cnt++; end
      cnt = 0;
      while (busy === 1'b1 && cnt < 400) begin tick(); cnt++; end
      check("frame_len_p9", cnt, 32'd279);
      cnt = 0;
      while (busy !== 1'b1 && cnt < 10) begin tick(); cnt++; end
      check("interframe_idle", cnt, 32'd1);
      wait_drain("drain_ovf", 2000);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Push and pop together at full
      rst_fix = 1'b1;
      tick();
      rst_fix = 1'b0;
      check("ovf_cleared", {31'd0, overflow}, 32'd0);
      tx_enable = 1'b0;
      strobe(4'b0001, 8'h12, 8'h34);
      strobe(4'b0010, 8'hFF, 8'h00);
      strobe(4'b0100, 8'h00, 8'hFF);
      strobe(4'b1000, 8'hA5, 8'h96);
      check("full_level", {29'd0, fifo_level}, 32'd4);
      expect3(8'h21, 8'h07, 8'h37);
      expect3(8'hF5, 8'h3F, 8'h03);
      expect3(8'h09, 8'hC3, 8'hFF);
      expect3(8'h5D, 8'hAB, 8'h97);
      expect3(8'hC9, 8'h4F, 8'h83);
      tx_enable = 1'b1;
      strobe(4'b0100, 8'h3C, 8'h81);
      check("pushpop_level", {29'd0, fifo_level}, 32'd4);
      check("pushpop_ovf", {31'd0, overflow}, 32'd0);
      wait_drain("drain_pushpop", 3000);

      // Baud floor: measured_baud below MIN_BAUD -> P = 434
      measured_baud = 16'd3;
      exp_p = 434;
      expect3(8'h01, 8'h03, 8'h03);
      strobe(4'b0001, 8'h00, 8'h00);
      tick();
      measured_baud = 16'd9;
      check("floor_start_line", {31'd0, cl_sertfg}, 32'd0);
      cnt = 1;
      while (cl_sertfg === 1'b0 && cnt < 1000) begin
         tick();
         if (cl_sertfg === 1'b0) cnt++;
      end
      check("floor_start_len", cnt, 32'd434);
      wait_drain("drain_floor", 14000);

      // Reset in the middle of a byte1 data bit
      mon_en = 1'b0;
      exp_p = 10;
      strobe(4'b0001, 8'h00, 8'h00);
      strobe(4'b0010, 8'h11, 8'h22);
      repeat (120) tick();
      check("midframe_busy", {31'd0, busy}, 32'd1);
      check("midframe_level", {29'd0, fifo_level}, 32'd1);
      rst_fix = 1'b1;
      tick();
      rst_fix = 1'b0;
      check("midrst_line", {31'd0, cl_sertfg}, 32'd1);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_level", {29'd0, fifo_level}, 32'd0);
      edges = 0;
      prev = cl_sertfg;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (cl_sertfg !== prev) edges++;
         prev = cl_sertfg;
      end
      check("midrst_quiet", edges, 32'd0);

      // Polarity swap
      mon_en = 1'b1;
      lvds_swap = 1'b1;
      tick();
      check("swap_idle", {31'd0, cl_sertfg}, 32'd0);
      expect3(8'hA5, 8'hD7, 8'hC3);
      strobe(4'b0010, 8'h5A, 8'hC3);
      tick();
      check("swap_start", {31'd0, cl_sertfg}, 32'd1);
      wait_drain("drain_swap", 500);
      check("swap_idle_after", {31'd0, cl_sertfg}, 32'd0);

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cl_serial_ack.md
# cl_serial_ack

Camera Link serial return-path transmitter. It sits directly downstream of the Camera Link serial command receiver and consumes its register-write strobes, address, data and measured baud period. It re-encodes each completed register write into the same 3-byte UART format and transmits it on SerTFG, so the host software gets a write acknowledge. A small FIFO decouples write bursts from the slow serial line.

## Interface
Parameters:
- FIFO_DEPTH, 4: acknowledge queue depth in entries (power of two).
- MIN_BAUD, 16'd8: smallest `measured_baud` accepted as valid.
- DEFAULT_BAUD, 16'd433: baud value used when `measured_baud` < MIN_BAUD.

Ports:
- clk_fix  in  1  system clock. All logic is clocked on the rising edge.
- rst_fix  in  1  synchronous, active-high reset.
- lvds_swap  in  1  pair-polarity swap. Line output is XORed with it.
- measured_baud  in  16  bit period minus one, in clk_fix cycles.
- rb1_wen, rb2_wen, rb3_wen, rb4_wen  in  1 each  single-cycle write strobes for register banks 0..3.
- reg_addr  in  8  write address. Valid in the strobe cycle.
- reg_data  in  8  write data. Valid in the strobe cycle.
- tx_enable  in  1  when high, new frames may start.
- cl_sertfg  out  1  serial line to the SerTFG LVDS buffer, `line_q ^ lvds_swap`.
- busy  out  1  a frame is in progress.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.
- fifo_level  out  3  number of queued entries, 0..FIFO_DEPTH.

## Operation
- **Capture.** In any cycle where a wen is high, form the entry {rb[1:0], addr[7:0], data[7:0]} (18 bits).
  - rb = 0..3 for rb1..rb4.
  - If several wen are high in the same cycle, the lowest bank index wins and only one entry is pushed.
- **Push.** Push if the FIFO is not full or a pop happens in the same cycle. Otherwise drop the entry and set `overflow`.
- **Frame start.** In IDLE, when the FIFO is non-empty and `tx_enable` = 1:
  - pop one entry;
  - latch the bit period P = (measured_baud < MIN_BAUD ? DEFAULT_BAUD : measured_baud) + 1;
  - load the three bytes:
    - byte0 = {A[3:0], RB, 2'b01}
    - byte1 = {D[1:0], A[7:4], 2'b11}
    - byte2 = {D[7:2], 2'b11}
- **Byte format.** Each byte is start bit 0, then 8 data bits LSB first, then stop bit 1. Every bit lasts exactly P cycles.
- **FSM.**
  - IDLE → START on frame start.
  - START → DATA after P cycles.
  - DATA → STOP after 8 bits.
  - STOP → START after P cycles if the byte counter < 2; otherwise STOP → GAP.
  - GAP: line held at 1 for P cycles, then → IDLE.
- **tx_enable deassertion.** A frame in progress completes. No new frame starts, and queued entries are retained.
- **measured_baud changes** mid-frame have no effect. P is re-latched only at the next frame start.

## Timing
- **Reset values:**
  - line_q = 1, so cl_sertfg = lvds_swap;
  - busy = 0, overflow = 0, fifo_level = 0;
  - FSM in IDLE and the FIFO emptied.
- **Reset mid-frame:** the frame is truncated. The line returns to idle on the clock edge where rst_fix is sampled high.
- **Push latency:** strobe in cycle N → fifo_level increments in cycle N+1.
- **Frame start from empty, idle, enabled:** strobe in N → pop in N+1 → cl_sertfg shows the start bit from N+2. busy rises in N+2.
- **Frame length:** 31·P cycles (30 bit times plus 1 gap bit). busy falls at the end of GAP.
- **Back-to-back frames:** the next pop occurs on the IDLE cycle after GAP, so there is one extra idle cycle between frames.
- **Simultaneous push and pop at full:** both succeed, fifo_level is unchanged and no overflow is raised.
- **Counter width:** the baud counter is 17 bits, so P = 65536 is legal without wrap.

## Structure
- Package `cl_serial_pkg` holds:
  - FSM state encodings (IDLE, START, DATA, STOP, GAP);
  - byte tag constants 2'b01 and 2'b11;
  - the entry width (18);
  - default MIN_BAUD and DEFAULT_BAUD;
  - the write-field layout, shared with the receiver.
- Sub-module `cl_sync_fifo`: a single-clock FIFO, parameterised by width and depth, with level output and same-cycle push/pop. The FSM, shift register and baud counter stay in the top level.

## Test plan
- **Single write.** measured_baud=9 (P=10), pulse rb2_wen with addr 0x5A, data 0xC3 → bytes 0xA5, 0xD7, 0xC3, each held 10 cycles per bit. busy stays high for 310 cycles.
- **Loopback.** Feed cl_sertfg into the upstream receiver (both lvds_swap=0) → rb2_wen pulses once with reg_addr=0x5A and reg_data=0xC3.
- **Overflow.** tx_enable=0, then 6 consecutive strobes → fifo_level=4 and overflow=1. After raising tx_enable, exactly the first 4 writes are transmitted in order.
- **Baud floor.** measured_baud=3 → bit period is DEFAULT_BAUD+1 = 434 cycles.
- **Reset mid-frame.** Assert rst_fix during a byte1 data bit → next cycle cl_sertfg=1, busy=0 and fifo_level=0. No further edges occur on the line.
- **Polarity swap.** lvds_swap=1 → idle level 0 and all transmitted bits inverted relative to the lvds_swap=0 case.
